// File: rtl/ps2_pkg.sv
// Shared constants, receiver state type and scan-code mapping for the PS/2 key decoder.
package ps2_pkg;

   localparam int unsigned KEY_W_BITS  = 4;
   localparam int unsigned CODE_W_BITS = 8;

   // key_press command codes
   localparam logic [KEY_W_BITS-1:0] KEY_NONE  = 4'b0000;
   localparam logic [KEY_W_BITS-1:0] KEY_A     = 4'b0001;
   localparam logic [KEY_W_BITS-1:0] KEY_D     = 4'b0010;
   localparam logic [KEY_W_BITS-1:0] KEY_S     = 4'b0011;
   localparam logic [KEY_W_BITS-1:0] KEY_W     = 4'b0100;
   localparam logic [KEY_W_BITS-1:0] KEY_SPACE = 4'b0101;

   // set-2 make codes and prefix bytes
   localparam logic [CODE_W_BITS-1:0] PS2_A     = 8'h1C;
   localparam logic [CODE_W_BITS-1:0] PS2_D     = 8'h23;
   localparam logic [CODE_W_BITS-1:0] PS2_S     = 8'h1B;
   localparam logic [CODE_W_BITS-1:0] PS2_W     = 8'h1D;
   localparam logic [CODE_W_BITS-1:0] PS2_SPACE = 8'h29;
   localparam logic [CODE_W_BITS-1:0] PS2_EXT   = 8'hE0;
   localparam logic [CODE_W_BITS-1:0] PS2_BRK   = 8'hF0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Translate a scan code into a key command; unmapped codes give KEY_NONE.
   function automatic logic [KEY_W_BITS-1:0] key_map(input logic [CODE_W_BITS-1:0] code);
      logic [KEY_W_BITS-1:0] k;
      k = KEY_NONE;
      case (code)
         PS2_A:     k = KEY_A;
         PS2_D:     k = KEY_D;
         PS2_S:     k = KEY_S;
         PS2_W:     k = KEY_W;
         PS2_SPACE: k = KEY_SPACE;
         default:   k = KEY_NONE;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM, odd-parity check and timeout.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ps2_clk,
   input  logic                   ps2_dat,
   output logic [CODE_W_BITS-1:0] code,
   output logic                   strobe,
   output logic                   err,
   output logic [CODE_W_BITS-1:0] rx_byte_c,
   output logic                   good_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic              clk_s1, clk_s2, clk_prev;
   logic              dat_s1, dat_s2;
   logic              fall;
   rx_state_t         state;
   logic [3:0]        bit_cnt;
   logic [7:0]        shift;
   logic              par_bit;
   logic [CNT_W-1:0]  tcnt;
   logic              timeout;

   // Two-flop synchronisers plus the previous-clock register for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat;
         dat_s2   <= dat_s1;
      end
   end

   assign fall      = clk_prev & ~clk_s2;
   assign timeout   = (state != RX_IDLE) && !fall && (tcnt >= CNT_W'(TIMEOUT_CYCLES));
   assign rx_byte_c = shift;
   // Stop bit high and 9 bits (data + parity) with an odd number of ones
   assign good_c    = (state == RX_STOP) && fall && dat_s2 && (^{shift, par_bit});

   // Frame FSM with timeout; an edge in the same cycle as the limit takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RX_IDLE;
         bit_cnt <= 4'd0;
         shift   <= 8'd0;
         par_bit <= 1'b0;
         tcnt    <= '0;
         code    <= '0;
         strobe  <= 1'b0;
         err     <= 1'b0;
      end else begin
         strobe <= 1'b0;
         err    <= 1'b0;

         if (state == RX_IDLE || fall) begin
            tcnt <= '0;
         end else if (tcnt != CNT_W'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + CNT_W'(1);
         end

         case (state)
            RX_IDLE: begin
               if (fall && !dat_s2) begin
                  state   <= RX_DATA;
                  bit_cnt <= 4'd0;
               end
            end
            RX_DATA: begin
               if (fall) begin
                  shift <= {dat_s2, shift[7:1]};
                  if (bit_cnt == 4'd7) begin
                     state <= RX_PARITY;
                  end
                  if (bit_cnt != 4'hF) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            RX_PARITY: begin
               if (fall) begin
                  par_bit <= dat_s2;
                  state   <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (fall) begin
                  if (good_c) begin
                     code   <= shift;
                     strobe <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
                  state <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase

         if (timeout) begin
            state <= RX_IDLE;
            err   <= 1'b1;
            tcnt  <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: maps W/A/S/D/space make/break sequences to a held 4-bit key command.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic                   PS2_CLK,
   input  logic                   PS2_DAT,
   output logic [KEY_W_BITS-1:0]  key_press,
   output logic                   key_valid,
   output logic [CODE_W_BITS-1:0] scan_code,
   output logic                   scan_strobe,
   output logic                   frame_err
);

   logic [CODE_W_BITS-1:0] rx_byte_c;
   logic                   good_c;
   logic [KEY_W_BITS-1:0]  mapped_c;
   logic                   ext_flag;
   logic                   brk_flag;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .ps2_clk   (PS2_CLK),
      .ps2_dat   (PS2_DAT),
      .code      (scan_code),
      .strobe    (scan_strobe),
      .err       (frame_err),
      .rx_byte_c (rx_byte_c),
      .good_c    (good_c)
   );

   assign mapped_c = key_map(rx_byte_c);

   // Prefix flags and held key, updated on the same edge that publishes scan_code
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         key_press <= KEY_NONE;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (good_c) begin
            if (rx_byte_c == PS2_EXT) begin
               ext_flag <= 1'b1;
            end else if (rx_byte_c == PS2_BRK) begin
               brk_flag <= 1'b1;
            end else if (ext_flag) begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end else if (brk_flag) begin
               brk_flag <= 1'b0;
               if (mapped_c != KEY_NONE && mapped_c == key_press) begin
                  key_press <= KEY_NONE;
                  key_valid <= 1'b1;
               end
            end else if (mapped_c != KEY_NONE && mapped_c != key_press) begin
               key_press <= mapped_c;
               key_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder using bit-banged PS/2 frames.
module tb_ps2_key_decoder;

   localparam int unsigned TO   = 200;  // shortened timeout for simulation
   localparam int          HALF = 20;   // PS/2 half bit period in system clocks

   logic       CLOCK_50;
   logic       resetn;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [3:0] key_press;
   logic       key_valid;
   logic [7:0] scan_code;
   logic       scan_strobe;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_strobe = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int s0, v0, e0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .PS2_CLK     (PS2_CLK),
      .PS2_DAT     (PS2_DAT),
      .key_press   (key_press),
      .key_valid   (key_valid),
      .scan_code   (scan_code),
      .scan_strobe (scan_strobe),
      .frame_err   (frame_err)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Pulse counters sampled on the inactive edge
   always @(negedge CLOCK_50) begin
      if (scan_strobe) n_strobe++;
      if (key_valid)   n_valid++;
      if (frame_err)   n_ferr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge CLOCK_50);
   endtask

   // Send the first nbits of a frame: start, 8 data LSB first, odd parity, stop
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
      logic [10:0] bits;
      bits[0]    = 1'b0;
      bits[8:1]  = b;
      bits[9]    = ~(^b) ^ bad_par;
      bits[10]   = ~bad_stop;
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = bits[i];
         wait_clk(HALF);
         PS2_CLK = 1'b0;
         wait_clk(HALF);
         PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
      if (nbits == 11) wait_clk(30);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   task automatic snap();
      s0 = n_strobe;
      v0 = n_valid;
      e0 = n_ferr;
   endtask

   initial begin
      resetn  = 1'b0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      wait_clk(4);
      #1;
      check("rst_key_press", 32'(key_press), 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_scan_code", 32'(scan_code), 32'h0);
      check("rst_strobe", 32'(scan_strobe), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      resetn = 1'b1;
      wait_clk(10);

      // W make
      snap();
      send(8'h1D);
      check("w_strobe_cnt", 32'(n_strobe - s0), 32'd1);
      check("w_scan_code", 32'(scan_code), 32'h1D);
      check("w_key_press", 32'(key_press), 32'h4);
      check("w_valid_cnt", 32'(n_valid - v0), 32'd1);

      // Typematic repeat then break
      snap();
      send(8'h1D); send(8'h1D); send(8'h1D);
      send(8'hF0);
      check("rep_key_press", 32'(key_press), 32'h4);
      check("rep_valid_cnt", 32'(n_valid - v0), 32'd0);
      check("rep_strobe_cnt", 32'(n_strobe - s0), 32'd4);
      check("brk_prefix_code", 32'(scan_code), 32'hF0);
      send(8'h1D);
      check("brk_w_key_press", 32'(key_press), 32'h0);
      check("brk_w_valid_cnt", 32'(n_valid - v0), 32'd1);

      // A then space, break of A leaves space held
      snap();
      send(8'h1C);
      check("a_key_press", 32'(key_press), 32'h1);
      send(8'h29);
      check("sp_key_press", 32'(key_press), 32'h5);
      send(8'hF0); send(8'h1C);
      check("brk_a_key_press", 32'(key_press), 32'h5);
      check("brk_a_scan_code", 32'(scan_code), 32'h1C);
      check("a_sp_valid_cnt", 32'(n_valid - v0), 32'd2);

      // Bad parity, then bad stop bit
      snap();
      send_frame(8'h1B, 1'b1, 1'b0, 11);
      send_frame(8'h1B, 1'b0, 1'b1, 11);
      check("bad_err_cnt", 32'(n_ferr - e0), 32'd2);
      check("bad_strobe_cnt", 32'(n_strobe - s0), 32'd0);
      check("bad_scan_code", 32'(scan_code), 32'h1C);
      check("bad_key_press", 32'(key_press), 32'h5);

      // Extended key ignored; partial frame stalls into a timeout
      snap();
      send(8'hE0); send(8'h75);
      check("ext_key_press", 32'(key_press), 32'h5);
      check("ext_valid_cnt", 32'(n_valid - v0), 32'd0);
      check("ext_scan_code", 32'(scan_code), 32'h75);
      send_frame(8'hF0, 1'b0, 1'b0, 4);
      wait_clk(2 * TO);
      check("to_err_cnt", 32'(n_ferr - e0), 32'd1);
      check("to_strobe_cnt", 32'(n_strobe - s0), 32'd2);
      send(8'h23);
      check("d_key_press", 32'(key_press), 32'h2);
      check("d_scan_code", 32'(scan_code), 32'h23);

      // Reset in the middle of a frame
      send_frame(8'h29, 1'b0, 1'b0, 6);
      wait_clk(5);
      resetn = 1'b0;
      #1;
      check("mrst_key_press", 32'(key_press), 32'h0);
      check("mrst_scan_code", 32'(scan_code), 32'h0);
      check("mrst_strobe", 32'(scan_strobe), 32'h0);
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      wait_clk(5);
      resetn = 1'b1;
      wait_clk(10);
      snap();
      send(8'h1D);
      check("post_rst_key_press", 32'(key_press), 32'h4);
      check("post_rst_scan_code", 32'(scan_code), 32'h1D);
      check("post_rst_err_cnt", 32'(n_ferr - e0), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
